// File: rtl/alu_issue_unit.sv
// Operand sequencer for the combinational ALU: owns the register file, issues one op at a time
// (IDLE->READ->EXEC->WB), writes back and returns the result. Define ALU_ISSUE_DBG_EN for the debug read port.
module alu_issue_unit #(
   parameter int N    = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_rs1,
   input  logic [AW-1:0] req_rs2,
   input  logic [AW-1:0] req_rd,
   output logic [N-1:0]  alu_x,
   output logic [N-1:0]  alu_y,
   input  logic [N-1:0]  alu_z,
   input  logic          alu_zf,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [N-1:0]  rsp_data,
   output logic          rsp_zf,
   output logic [AW-1:0] rsp_rd,
   input  logic          init_we,
   input  logic [AW-1:0] init_waddr,
   input  logic [N-1:0]  init_wdata
`ifdef ALU_ISSUE_DBG_EN
   ,
   input  logic [AW-1:0] dbg_raddr,
   output logic [N-1:0]  dbg_rdata
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_EXEC = 2'd2;
   localparam logic [1:0] ST_WB   = 2'd3;

   // r0 has no storage: every read/write loop starts at index 1, so r0 reads 0 and drops writes
   logic [N-1:0]  regs_r [NREG-1:1];

   logic [1:0]    state_r;
   logic [AW-1:0] rs1_r;
   logic [AW-1:0] rs2_r;
   logic [AW-1:0] rd_r;
   logic          req_ready_r;
   logic          rsp_valid_r;
   logic [N-1:0]  alu_x_r;
   logic [N-1:0]  alu_y_r;
   logic [N-1:0]  rsp_data_r;
   logic          rsp_zf_r;
   logic [AW-1:0] rsp_rd_r;

   logic          accept_s;
   logic [N-1:0]  rs1_val_s;
   logic [N-1:0]  rs2_val_s;
   logic          wr_en_s;
   logic [AW-1:0] wr_idx_s;
   logic [N-1:0]  wr_data_s;

   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign alu_x     = alu_x_r;
   assign alu_y     = alu_y_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_zf    = rsp_zf_r;
   assign rsp_rd    = rsp_rd_r;

   // Request handshake qualifier
   always_comb begin
      accept_s = 1'b0;
      if (state_r == ST_IDLE) begin
         accept_s = req_valid & req_ready_r;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Source operand read muxes; indices 0 and >= NREG match nothing and yield 0
   always_comb begin
      rs1_val_s = {N{1'b0}};
      rs2_val_s = {N{1'b0}};
      for (int i = 1; i < NREG; i++) begin
         rs1_val_s = (rs1_r == AW'(i)) ? regs_r[i] : rs1_val_s;
         rs2_val_s = (rs2_r == AW'(i)) ? regs_r[i] : rs2_val_s;
      end
   end

   // Single register-file write port shared by preload (IDLE) and writeback (EXEC)
   always_comb begin
      wr_en_s   = 1'b0;
      wr_idx_s  = init_waddr;
      wr_data_s = init_wdata;
      case (state_r)
         ST_IDLE: begin
            wr_en_s   = init_we;
            wr_idx_s  = init_waddr;
            wr_data_s = init_wdata;
         end
         ST_EXEC: begin
            wr_en_s   = 1'b1;
            wr_idx_s  = rd_r;
            wr_data_s = alu_z;
         end
         default: begin
            wr_en_s   = 1'b0;
            wr_idx_s  = init_waddr;
            wr_data_s = init_wdata;
         end
      endcase
   end

   // Register file storage
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < NREG; i++) begin
            regs_r[i] <= {N{1'b0}};
         end
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (wr_en_s && (wr_idx_s == AW'(i))) begin
               regs_r[i] <= wr_data_s;
            end
         end
      end
   end

   // Issue sequencer and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         rs1_r       <= {AW{1'b0}};
         rs2_r       <= {AW{1'b0}};
         rd_r        <= {AW{1'b0}};
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         alu_x_r     <= {N{1'b0}};
         alu_y_r     <= {N{1'b0}};
         rsp_data_r  <= {N{1'b0}};
         rsp_zf_r    <= 1'b0;
         rsp_rd_r    <= {AW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  rs1_r       <= req_rs1;
                  rs2_r       <= req_rs2;
                  rd_r        <= req_rd;
                  req_ready_r <= 1'b0;
                  state_r     <= ST_READ;
               end
            end
            ST_READ: begin
               alu_x_r <= rs1_val_s;
               alu_y_r <= rs2_val_s;
               state_r <= ST_EXEC;
            end
            ST_EXEC: begin
               rsp_data_r  <= alu_z;
               rsp_zf_r    <= alu_zf;
               rsp_rd_r    <= rd_r;
               rsp_valid_r <= 1'b1;
               state_r     <= ST_WB;
            end
            ST_WB: begin
               // Response fields stay frozen until the consumer takes them
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  req_ready_r <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               req_ready_r <= 1'b1;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ALU_ISSUE_DBG_EN
   // Debug read port, combinational from the register file
   always_comb begin
      dbg_rdata = {N{1'b0}};
      for (int i = 1; i < NREG; i++) begin
         dbg_rdata = (dbg_raddr == AW'(i)) ? regs_r[i] : dbg_rdata;
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: a plain-arithmetic register model predicts every response.
// Debug-port checks are active when ALU_ISSUE_DBG_EN is defined for the build.
module tb_alu_issue_unit;
   localparam int N    = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   typedef struct packed {
      logic          zf;
      logic [AW-1:0] rd;
      logic [N-1:0]  z;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready;
   logic [AW-1:0] req_rs1, req_rs2, req_rd;
   logic [N-1:0]  alu_x, alu_y, alu_z;
   logic          alu_zf;
   logic          rsp_valid, rsp_ready;
   logic [N-1:0]  rsp_data;
   logic          rsp_zf;
   logic [AW-1:0] rsp_rd;
   logic          init_we;
   logic [AW-1:0] init_waddr;
   logic [N-1:0]  init_wdata;
`ifdef ALU_ISSUE_DBG_EN
   logic [AW-1:0] dbg_raddr;
   logic [N-1:0]  dbg_rdata;
`endif

   logic [N-1:0]  m_regs [NREG];
   int            vectors = 0;
   int            miscompares = 0;

   always #5 clk = ~clk;

   // Bench ALU: wrapping add, zero flag
   assign alu_z  = alu_x + alu_y;
   assign alu_zf = (alu_z == {N{1'b0}});

   alu_issue_unit #(.N(N), .NREG(NREG), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
      .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z), .alu_zf(alu_zf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_zf(rsp_zf), .rsp_rd(rsp_rd),
      .init_we(init_we), .init_waddr(init_waddr), .init_wdata(init_wdata)
`ifdef ALU_ISSUE_DBG_EN
      , .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
`endif
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) m_regs[i] = {N{1'b0}};
   endtask

   task automatic init_write(input logic [AW-1:0] a, input logic [N-1:0] d);
      init_we = 1'b1; init_waddr = a; init_wdata = d;
      tick();
      init_we = 1'b0;
      if (a != 0) m_regs[a] = d;
   endtask

   // One complete operation with rsp_ready held low until the response has been checked
   task automatic run_op(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                         input logic iw = 1'b0, input logic [AW-1:0] ia = 5'd0, input logic [N-1:0] id = 32'd0);
      logic [N-1:0] ez;
      logic         ezf;
      if (iw && ia != 0) m_regs[ia] = id;
      ez  = m_regs[rs1] + m_regs[rs2];
      ezf = (ez == {N{1'b0}});
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++; $display("FAIL op_idle_ready: got %b want 1", req_ready);
      end
      req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
      init_we = iw; init_waddr = ia; init_wdata = id;
      tick();
      req_valid = 1'b0; init_we = 1'b0;
      vectors++;
      if ({rsp_valid, req_ready} !== 2'b00) begin
         miscompares++; $display("FAIL op_busy: got valid/ready %b want 00", {rsp_valid, req_ready});
      end
      tick();
      vectors++;
      if ({alu_x, alu_y} !== {m_regs[rs1], m_regs[rs2]}) begin
         miscompares++; $display("FAIL op_operands: got x=%h y=%h want x=%h y=%h", alu_x, alu_y, m_regs[rs1], m_regs[rs2]);
      end
      tick();
      tick();
      vectors++;
      if ({rsp_valid, rsp_zf, rsp_rd, rsp_data} !== {1'b1, ezf, rd, ez}) begin
         miscompares++;
         $display("FAIL op_result: got v=%b zf=%b rd=%0d data=%h want v=1 zf=%b rd=%0d data=%h",
                  rsp_valid, rsp_zf, rsp_rd, rsp_data, ezf, rd, ez);
      end
      if (rd != 0) m_regs[rd] = ez;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      vectors++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         miscompares++; $display("FAIL op_release: got valid/ready %b want 01", {rsp_valid, req_ready});
      end
`ifdef ALU_ISSUE_DBG_EN
      dbg_raddr = rd;
      #1;
      vectors++;
      if (dbg_rdata !== m_regs[rd]) begin
         miscompares++; $display("FAIL op_dbg_rd: got r%0d=%h want %h", rd, dbg_rdata, m_regs[rd]);
      end
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
      vectors++;
      if ({req_ready, rsp_valid, alu_x, alu_y, rsp_data, rsp_zf, rsp_rd} !== {1'b1, 1'b0, {(3*N+1+AW){1'b0}}}) begin
         miscompares++;
         $display("FAIL reset_outputs: got ready=%b valid=%b x=%h y=%h data=%h zf=%b rd=%0d want 1 0 and zeros",
                  req_ready, rsp_valid, alu_x, alu_y, rsp_data, rsp_zf, rsp_rd);
      end
`ifdef ALU_ISSUE_DBG_EN
      for (int i = 0; i < NREG; i++) begin
         dbg_raddr = AW'(i);
         #1;
         vectors++;
         if (dbg_rdata !== {N{1'b0}}) begin
            miscompares++; $display("FAIL reset_reg: got r%0d=%h want 0", i, dbg_rdata);
         end
      end
`endif
   endtask

   task automatic test_basic_add();
      init_write(5'd1, 32'h112233ff);
      init_write(5'd2, 32'h00000001);
      run_op(5'd1, 5'd2, 5'd3);
      vectors++;
      if (m_regs[3] !== 32'h11223400) begin
         miscompares++; $display("FAIL basic_model: got %h want 11223400", m_regs[3]);
      end
   endtask

   task automatic test_wrap_zero();
      init_write(5'd4, 32'hffffffff);
      init_write(5'd5, 32'h00000001);
      run_op(5'd4, 5'd5, 5'd6);
      init_write(5'd7, 32'hffffffff);
      run_op(5'd4, 5'd7, 5'd8);
      run_op(5'd6, 5'd0, 5'd0);
   endtask

   task automatic test_r0();
      run_op(5'd1, 5'd0, 5'd0);
      init_write(5'd0, 32'hdeadbeef);
      run_op(5'd0, 5'd0, 5'd12);
      run_op(5'd12, 5'd1, 5'd13, 1'b1, 5'd12, 32'h0000_1000);
   endtask

   task automatic test_backpressure();
      logic [N-1:0] ez;
      ez = m_regs[2] + m_regs[1];
      req_valid = 1'b1; req_rs1 = 5'd2; req_rs2 = 5'd1; req_rd = 5'd11;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      tick();
      m_regs[11] = ez;
      for (int c = 0; c < 5; c++) begin
         req_valid = 1'b1; req_rs1 = AW'($urandom_range(31, 0)); req_rs2 = 5'd3; req_rd = 5'd14;
         init_we = 1'b1; init_waddr = 5'd9; init_wdata = $urandom;
         vectors++;
         if ({rsp_valid, req_ready, rsp_zf, rsp_rd, rsp_data} !== {1'b1, 1'b0, (ez == {N{1'b0}}), 5'd11, ez}) begin
            miscompares++;
            $display("FAIL bp_hold: got v=%b rdy=%b zf=%b rd=%0d data=%h want v=1 rdy=0 rd=11 data=%h",
                     rsp_valid, req_ready, rsp_zf, rsp_rd, rsp_data, ez);
         end
         tick();
      end
      req_valid = 1'b0; init_we = 1'b0; rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      vectors++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         miscompares++; $display("FAIL bp_release: got valid/ready %b want 01", {rsp_valid, req_ready});
      end
      run_op(5'd9, 5'd0, 5'd0);
      run_op(5'd11, 5'd0, 5'd0);
   endtask

   task automatic test_random_ops();
      logic [AW-1:0] a, b, d;
      for (int k = 0; k < 10; k++) begin
         a = AW'($urandom_range(31, 0));
         b = AW'($urandom_range(31, 0));
         d = AW'($urandom_range(31, 0));
         if (k % 3 == 0 && b != 0) init_write(b, {N{1'b0}} - m_regs[a]);
         else init_write(AW'($urandom_range(31, 1)), $urandom);
         run_op(a, b, d);
      end
   endtask

   task automatic test_back_to_back();
      exp_t q[$];
      exp_t e;
      int   accepts = 0;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_rs1 = AW'($urandom_range(31, 0)); req_rs2 = AW'($urandom_range(31, 0)); req_rd = AW'($urandom_range(31, 0));
      for (int c = 0; c < 40; c++) begin
         if (rsp_valid === 1'b1) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++; $display("FAIL b2b_spurious: got rsp_valid 1 want 0");
            end else begin
               e = q.pop_front();
               if ({rsp_zf, rsp_rd, rsp_data} !== e) begin
                  miscompares++;
                  $display("FAIL b2b_result: got zf=%b rd=%0d data=%h want zf=%b rd=%0d data=%h",
                           rsp_zf, rsp_rd, rsp_data, e.zf, e.rd, e.z);
               end
            end
         end
         if (req_ready === 1'b1) begin
            e.z  = m_regs[req_rs1] + m_regs[req_rs2];
            e.zf = (e.z == {N{1'b0}});
            e.rd = req_rd;
            q.push_back(e);
            if (req_rd != 0) m_regs[req_rd] = e.z;
            accepts++;
         end
         tick();
         req_rs1 = AW'($urandom_range(31, 0)); req_rs2 = AW'($urandom_range(31, 0)); req_rd = AW'($urandom_range(31, 0));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      vectors++;
      if (accepts !== 10 || q.size() !== 0) begin
         miscompares++; $display("FAIL b2b_throughput: got %0d accepts, %0d pending want 10, 0", accepts, q.size());
      end
   endtask

   task automatic test_reset_mid_op();
      req_valid = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd2; req_rd = 5'd10;
      tick();
      req_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
      vectors++;
      if ({rsp_valid, req_ready, alu_x, alu_y, rsp_data} !== {1'b0, 1'b1, {(3*N){1'b0}}}) begin
         miscompares++;
         $display("FAIL rst_mid_outputs: got v=%b rdy=%b x=%h y=%h data=%h want 0 1 zeros",
                  rsp_valid, req_ready, alu_x, alu_y, rsp_data);
      end
      tick();
      vectors++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         miscompares++; $display("FAIL rst_mid_idle: got valid/ready %b want 01", {rsp_valid, req_ready});
      end
      run_op(5'd10, 5'd0, 5'd0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_rd = 5'd0;
      rsp_ready = 1'b0; init_we = 1'b0; init_waddr = 5'd0; init_wdata = 32'd0;
`ifdef ALU_ISSUE_DBG_EN
      dbg_raddr = 5'd0;
`endif
      @(negedge clk);
      test_reset();
      test_basic_add();
      test_wrap_zero();
      test_r0();
      test_backpressure();
      test_random_ops();
      test_back_to_back();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
